// File: rtl/pcie_ss_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module   : pcie_ss_ctrl_arb
// Brief    : Round-robin arbiter and sequencer sharing the PCIe subsystem
//            sideband control port between NUM_REQ requesters. Holds each
//            command until the subsystem acks, then returns the result to
//            the owner. Optional watchdog enabled by PCIE_SS_CTRL_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_ss_ctrl_arb #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 18,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [2*NUM_REQ-1:0]          req_cmd,
  input  logic [ADDR_WIDTH*NUM_REQ-1:0] req_addr,
  input  logic [32*NUM_REQ-1:0]         req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [31:0]                   rsp_rdata,
  output logic                          rsp_error,
  output logic                          rsp_timeout,
  output logic [1:0]                    o_ss_ctrl_cmd,
  output logic [ADDR_WIDTH-1:0]         o_ss_ctrl_addr,
  output logic [31:0]                   o_ss_ctrl_writedata,
  input  logic [31:0]                   i_ss_readdata,
  input  logic                          i_ss_ack,
  input  logic                          i_ss_error,
  output logic [15:0]                   o_timeout_cnt
);

  localparam int         IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int         CW     = IDX_W + 1;
  localparam logic [1:0] CMD_RD = 2'b01;
  localparam logic [1:0] CMD_WR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        last_grant_q, last_grant_d;
  logic [1:0]              cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    error_q, error_d;
  logic                    timeout_q, timeout_d;

  logic                    grant_found;
  logic [IDX_W-1:0]        grant_idx;
  logic [CW-1:0]           cand;
  logic [1:0]              sel_cmd;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [31:0]             sel_wdata;
  logic                    wd_expired;

  // Round-robin search starting one past the last owner, then mux that requester's fields
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    sel_cmd     = '0;
    sel_addr    = '0;
    sel_wdata   = '0;
    req_ready   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, last_grant_q} + CW'(i + 1);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (!grant_found && req_valid[cand[IDX_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_cmd   = req_cmd[2*i +: 2];
        sel_addr  = req_addr[ADDR_WIDTH*i +: ADDR_WIDTH];
        sel_wdata = req_wdata[32*i +: 32];
      end
      req_ready[i] = (state_q == ST_IDLE) && grant_found && (grant_idx == IDX_W'(i));
    end
  end

  // Next-state and response capture; response fields are non-zero only while in DONE
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cmd_d        = cmd_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = '0;
    error_d      = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          owner_d = grant_idx;
          cmd_d   = sel_cmd;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          if (sel_cmd == CMD_RD || sel_cmd == CMD_WR) begin
            state_d = ST_BUSY;
          end else begin
            // Illegal command never reaches the subsystem
            state_d = ST_DONE;
            error_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        // An ack in the expiry cycle takes precedence over the watchdog
        if (i_ss_ack) begin
          state_d = ST_DONE;
          rdata_d = (cmd_q == CMD_RD) ? i_ss_readdata : 32'h0;
          error_d = i_ss_error;
        end else if (wd_expired) begin
          state_d   = ST_DONE;
          rdata_d   = 32'hFFFF_FFFF;
          error_d   = 1'b1;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d      = ST_IDLE;
        last_grant_d = owner_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Arbiter/sequencer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      cmd_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cmd_q        <= cmd_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      error_q      <= error_d;
      timeout_q    <= timeout_d;
    end
  end

  // Sideband port is driven only in BUSY, so reset or turnaround forces it idle
  always_comb begin
    o_ss_ctrl_cmd       = (state_q == ST_BUSY) ? cmd_q   : 2'b00;
    o_ss_ctrl_addr      = (state_q == ST_BUSY) ? addr_q  : '0;
    o_ss_ctrl_writedata = (state_q == ST_BUSY) ? wdata_q : 32'h0;
    rsp_rdata           = rdata_q;
    rsp_error           = error_q;
    rsp_timeout         = timeout_q;
    rsp_valid           = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == ST_DONE) && (owner_q == IDX_W'(i));
    end
  end

`ifdef PCIE_SS_CTRL_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic [15:0]     timeout_cnt_q, timeout_cnt_d;

  assign wd_expired    = (state_q == ST_BUSY) && (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1));
  assign o_timeout_cnt = timeout_cnt_q;

  // Watchdog counts BUSY cycles from zero; expiry count saturates
  always_comb begin
    wd_cnt_d      = '0;
    timeout_cnt_d = timeout_cnt_q;
    if (state_q == ST_BUSY) wd_cnt_d = wd_cnt_q + 1'b1;
    if (wd_expired && !i_ss_ack && (timeout_cnt_q != 16'hFFFF)) begin
      timeout_cnt_d = timeout_cnt_q + 16'd1;
    end
  end

  // Watchdog registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q      <= '0;
      timeout_cnt_q <= '0;
    end else begin
      wd_cnt_q      <= wd_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end
`else
  assign wd_expired    = 1'b0;
  assign o_timeout_cnt = 16'h0;

  // Watchdog compiled out; TIMEOUT_CYCLES kept only for interface compatibility
  if (TIMEOUT_CYCLES < 4) begin : g_timeout_param_unused
  end
`endif

endmodule
`default_nettype wire

// File: doc/pcie_ss_ctrl_arb.md
# pcie_ss_ctrl_arb

Arbiter and sequencer for the PCIe subsystem sideband control port (cmd/addr/writedata out, readdata/ack/error in). It shares that single port between NUM_REQ requesters, such as the PCIe CSR software path and a hardware link-init sequencer. It grants round-robin, holds each command until the subsystem acks, and returns the result to the owner. An optional watchdog terminates commands the subsystem never acks.

## Interface
Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- ADDR_WIDTH, 18, sideband address width; instantiated with ofs_fim_cfg_pkg::PCIE_LITE_CSR_WIDTH
- TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles (≥4); used only with PCIE_SS_CTRL_TIMEOUT_EN

Ports:
- clk  in  1  single clock domain
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  request pending, held until accepted
- req_cmd  in  2*NUM_REQ  per requester: 2'b01 read, 2'b10 write, others illegal
- req_addr  in  ADDR_WIDTH*NUM_REQ  per requester address
- req_wdata  in  32*NUM_REQ  per requester write data
- req_ready  out  NUM_REQ  one-hot accept pulse (combinational)
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response to the accepted requester
- rsp_rdata  out  32  read data, valid with rsp_valid
- rsp_error  out  1  subsystem error, illegal command or timeout
- rsp_timeout  out  1  response caused by the watchdog
- o_ss_ctrl_cmd  out  2  command to the subsystem; 0 = idle
- o_ss_ctrl_addr  out  ADDR_WIDTH
- o_ss_ctrl_writedata  out  32
- i_ss_readdata  in  32
- i_ss_ack  in  1  single-cycle completion
- i_ss_error  in  1  qualified by i_ss_ack
- o_timeout_cnt  out  16  saturating count of watchdog expiries

## Operation
- FSM states:
  - IDLE: accepts a request.
  - BUSY: command driven on the sideband port.
  - DONE: one-cycle turnaround.
- IDLE: if any req_valid is set, grant round-robin starting at last_grant+1. Assert req_ready[g]. Latch owner, cmd, addr and wdata.
  - Legal cmd: go to BUSY.
  - Illegal cmd: go to DONE with rsp_error=1 and rdata=0; nothing is driven downstream.
- BUSY: o_ss_ctrl_cmd/addr/writedata are held constant. When i_ss_ack=1:
  - capture i_ss_readdata into rsp_rdata (writes return 0);
  - capture i_ss_error into rsp_error;
  - go to DONE.
- DONE: o_ss_ctrl_cmd=0 and rsp_valid[owner]=1 for exactly one cycle; last_grant ← owner. Next state is IDLE.
- i_ss_ack outside BUSY is ignored.
- Arbitration fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Reset values:
  - FSM in IDLE, last_grant=NUM_REQ-1 (requester 0 has first priority);
  - all outputs 0, o_timeout_cnt=0.

## Timing
- Accept at cycle T; o_ss_ctrl_cmd valid from T+1.
- Ack at cycle A ≥ T+1 → rsp_valid at A+1, and o_ss_ctrl_cmd=0 at A+1.
- Illegal cmd accepted at T → rsp_valid at T+1.
- Next accept is no earlier than the cycle after DONE. Minimum period per legal command is 3 cycles.
- rsp_rdata, rsp_error and rsp_timeout are registered. They are valid only while rsp_valid is set and are 0 otherwise.
- Asserting rst at any time, including mid-BUSY, immediately forces o_ss_ctrl_cmd=0, the FSM to IDLE and all outputs to 0. No response is generated for the aborted command.

## Configuration
- PCIE_SS_CTRL_TIMEOUT_EN defined:
  - A cycle counter clears on entry to BUSY.
  - If it reaches TIMEOUT_CYCLES-1 with no ack, go to DONE with rsp_error=1, rsp_timeout=1 and rsp_rdata=32'hFFFF_FFFF; o_timeout_cnt increments, saturating at 16'hFFFF.
  - If the ack arrives in the same cycle the counter expires, the ack wins (normal completion).
- Not defined: BUSY waits indefinitely. rsp_timeout and o_timeout_cnt are tied to 0 and no counter logic is generated.

## Test plan
- Single read: req0 cmd=01, addr=18'h0100; subsystem acks 3 cycles after cmd with readdata=32'hCAFE_F00D, error=0.
  - Expect: rsp_valid[0] one cycle after ack, rdata=CAFE_F00D, error=0; o_ss_ctrl_cmd=0 in that cycle.
- Round-robin: req0 and req1 both write continuously, 4 transactions.
  - Expect: grant order 0,1,0,1; each response goes to the correct requester; cmd is held stable until each ack.
- Subsystem error: write to 18'h0200, ack with i_ss_error=1.
  - Expect: rsp_error=1, rsp_timeout=0, rdata=0.
- Illegal command: req1 cmd=11.
  - Expect: o_ss_ctrl_cmd stays 0, rsp_valid[1] at T+1 with error=1.
- Timeout (macro on, TIMEOUT_CYCLES=16): never ack.
  - Expect: response with error=1, timeout=1, rdata=FFFF_FFFF and o_timeout_cnt=1.
  - Repeat with the ack on the expiry cycle: normal completion, o_timeout_cnt unchanged.
- Reset mid-BUSY: assert rst 2 cycles after cmd is issued.
  - Expect: cmd=0 asynchronously, no rsp_valid, a stray ack afterwards is ignored, and the next request is accepted normally.
